riscv_pipe_ctrl: RTL and testbench
==================================

// Module: riscv_pipe_ctrl
// PURPOSE
//  Pipeline instruction-register chain and hazard controller for the 5-stage RISC-V core.
//  - Captures the fetched instruction and shifts it through ID/EX/MEM/WB as inst_s2..inst_s5.
//  - These registers drive the forwarding unit and the stage decoders.
//  - Inserts load-use bubbles, flushes on taken branch/jump and freezes the pipe on data-memory wait.
// PARAMETERS
//  LU_BUBBLES  1       load-use bubble cycles injected into EX, legal range 1..3
//  NOP_INST    32'h00000013  bubble encoding (addi x0,x0,0)
//  CNT_W       16      width of performance counters
// PORTS
//  clk           in   1      core clock
//  rst           in   1      synchronous reset, active-high
//  inst_if       in   32     instruction from fetch
//  inst_if_vld   in   1      inst_if is valid this cycle
//  branch_taken  in   1      branch/jump in EX (inst_s3) resolved taken
//  dmem_ready    in   1      data memory done; 0 = MEM access pending
//  inst_s2       out  32     ID-stage instruction
//  inst_s3       out  32     EX-stage instruction
//  inst_s4       out  32     MEM-stage instruction
//  inst_s5       out  32     WB-stage instruction
//  stall_if      out  1      combinational: PC and fetch must hold this cycle
//  stall_cnt     out  CNT_W  saturating count of stall cycles (perf)
//  flush_cnt     out  CNT_W  saturating count of flush events (perf)
// BEHAVIOUR
//  Reset and timing
//  - Reset: inst_s2..s5 = NOP_INST; FSM = RUN; bubble counter = 0; stall_cnt = flush_cnt = 0.
//  - All inst_sN are registered; an instruction moves one stage per unstalled cycle.
//  Hazard detection (combinational, on current regs)
//  - hz: inst_s3 opcode LOAD (7'b0000011) and rd != 0, and either:
//    - rd == inst_s2[19:15] with s2 opcode R/I/LOAD/S/B; or
//    - rd == inst_s2[24:20] with s2 opcode R/S/B.
//  Priority per cycle: freeze > flush > load-use > normal.
//  - Freeze (dmem_ready=0)
//    - All inst_sN hold; FSM and counter hold; stall_if=1.
//    - branch_taken is ignored; it stays asserted while s3 is held.
//  - Flush (branch_taken=1, dmem_ready=1)
//    - s5<=s4, s4<=s3, s3<=NOP, s2<=NOP; stall_if=0 (fetch redirects).
//    - FSM forced to RUN; flush_cnt++.
//  - Load-use, RUN state with hz=1
//    - s2 holds, s3<=NOP, s4<=s3, s5<=s4; stall_if=1.
//    - If LU_BUBBLES>1: go to HOLD, counter<=LU_BUBBLES-1.
//  - HOLD state
//    - s2 holds, s3<=NOP, s4/s5 advance; stall_if=1; counter--.
//    - counter==1 -> RUN on the next edge. hz is not re-evaluated in HOLD.
//  - Normal
//    - s2 <= inst_if_vld ? inst_if : NOP; s3<=s2; s4<=s3; s5<=s4; stall_if=0.
//  - stall_cnt increments on every cycle with stall_if=1.
//  - Both counters saturate at all-ones; no wrap.
//  - rst asserted mid-stall or mid-freeze: every register returns to its reset value on the next edge.
// CONFIGURATION
//  RISCV_PIPE_PERF_EN
//  - Defined: stall_cnt/flush_cnt are implemented as described.
//  - Undefined: no counter flops; stall_cnt and flush_cnt tie to 0.
//  - Pipeline behaviour is identical either way.
// TESTING
//  - Reset: assert rst 2 cycles -> inst_s2..s5 = 0x00000013, stall_if=0, counters 0.
//  - Stream: feed 4 distinct valid inst -> each appears in s2,s3,s4,s5 on successive cycles.
//  - Load-use, LU_BUBBLES=1: lw x5,0(x1)=0x0000A283 then add x6,x5,x2=0x00228333.
//    - Expect 1 cycle stall_if=1, NOP in s3, add stays in s2, stall_cnt=1.
//  - Same pair with LU_BUBBLES=3 -> 3 stall cycles, 3 consecutive NOPs in s3.
//  - Flush: branch_taken=1 with hz=1 -> s2=s3=NOP next cycle, stall_if=0, flush_cnt=1.
//  - Freeze: dmem_ready=0 for 4 cycles during HOLD -> all regs frozen; bubble count resumes after.
//  - Saturation: with CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/riscv_pipe_ctrl.sv
// Instruction-register chain and hazard controller for the 5-stage core.
// Optional perf counters are built only when RISCV_PIPE_PERF_EN is defined.
module riscv_pipe_ctrl #(
  parameter int          LU_BUBBLES = 1,
  parameter logic [31:0] NOP_INST   = 32'h00000013,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_if,
  input  logic             inst_if_vld,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic [31:0]      inst_s2,
  output logic [31:0]      inst_s3,
  output logic [31:0]      inst_s4,
  output logic [31:0]      inst_s5,
  output logic             stall_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int         BW      = 2;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BRCH = 7'b1100011;

  logic [31:0]   r_s2;
  logic [31:0]   r_s3;
  logic [31:0]   r_s4;
  logic [31:0]   r_s5;
  logic [0:0]    r_state;
  logic [BW-1:0] r_cnt;

  logic [31:0]   w_s2_nx;
  logic [31:0]   w_s3_nx;
  logic [31:0]   w_s4_nx;
  logic [31:0]   w_s5_nx;
  logic [0:0]    w_state_nx;
  logic [BW-1:0] w_cnt_nx;

  logic [6:0] w_op2;
  logic [6:0] w_op3;
  logic [4:0] w_rd3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use1;
  logic       w_use2;
  logic       w_hz;
  logic       w_lu;
  logic       w_hold;
  logic       w_frz;
  logic       w_flush;
  logic       w_bub;
  logic       w_run;

  assign w_op2 = r_s2[6:0];
  assign w_op3 = r_s3[6:0];
  assign w_rd3 = r_s3[11:7];
  assign w_rs1 = r_s2[19:15];
  assign w_rs2 = r_s2[24:20];

  assign w_use1 = (w_op2 == OP_REG)  || (w_op2 == OP_IMM) ||
                  (w_op2 == OP_LOAD) || (w_op2 == OP_STOR) ||
                  (w_op2 == OP_BRCH);
  assign w_use2 = (w_op2 == OP_REG)  || (w_op2 == OP_STOR) ||
                  (w_op2 == OP_BRCH);

  assign w_hz = (w_op3 == OP_LOAD) && (w_rd3 != 5'd0) &&
                ((w_use1 && (w_rd3 == w_rs1)) ||
                 (w_use2 && (w_rd3 == w_rs2)));

  assign w_lu   = (r_state == ST_RUN) && w_hz;
  assign w_hold = (r_state == ST_HOLD);

  // Mutually exclusive cycle classes in priority order
  assign w_frz   = !dmem_ready;
  assign w_flush = dmem_ready && branch_taken;
  assign w_bub   = dmem_ready && !branch_taken && (w_lu || w_hold);
  assign w_run   = dmem_ready && !branch_taken && !(w_lu || w_hold);

  assign stall_if = w_frz || w_bub;

  always_comb begin
    w_s2_nx    = r_s2;
    w_s3_nx    = r_s3;
    w_s4_nx    = r_s4;
    w_s5_nx    = r_s5;
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (1'b1)
      w_frz: begin
      end
      w_flush: begin
        w_s2_nx    = NOP_INST;
        w_s3_nx    = NOP_INST;
        w_s4_nx    = r_s3;
        w_s5_nx    = r_s4;
        w_state_nx = ST_RUN;
        w_cnt_nx   = '0;
      end
      w_bub: begin
        w_s3_nx = NOP_INST;
        w_s4_nx = r_s3;
        w_s5_nx = r_s4;
        if (w_hold) begin
          w_cnt_nx = r_cnt - 1'b1;
          if (r_cnt == BW'(1)) begin
            w_state_nx = ST_RUN;
          end
        end else if (LU_BUBBLES > 1) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = BW'(LU_BUBBLES - 1);
        end
      end
      w_run: begin
        w_s2_nx = inst_if_vld ? inst_if : NOP_INST;
        w_s3_nx = r_s2;
        w_s4_nx = r_s3;
        w_s5_nx = r_s4;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2    <= NOP_INST;
      r_s3    <= NOP_INST;
      r_s4    <= NOP_INST;
      r_s5    <= NOP_INST;
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_s2    <= w_s2_nx;
      r_s3    <= w_s3_nx;
      r_s4    <= w_s4_nx;
      r_s5    <= w_s5_nx;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign inst_s2 = r_s2;
  assign inst_s3 = r_s3;
  assign inst_s4 = r_s4;
  assign inst_s5 = r_s5;

`ifdef RISCV_PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: table-driven vectors on a
// LU_BUBBLES=1 instance plus hand sequences on a LU_BUBBLES=3, CNT_W=4 one.
module tb_riscv_pipe_ctrl;

`ifdef RISCV_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] N   = 32'h00000013;
  localparam logic [31:0] IA  = 32'h00100093;
  localparam logic [31:0] IB  = 32'h00200113;
  localparam logic [31:0] IC  = 32'h00300193;
  localparam logic [31:0] ID  = 32'h00400213;
  localparam logic [31:0] LW  = 32'h0000A283;
  localparam logic [31:0] ADD = 32'h00228333;
  localparam logic [31:0] IF7 = 32'h00700393;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_if;
  logic        vld;
  logic        br;
  logic        rdy;

  logic [31:0] a_s2, a_s3, a_s4, a_s5;
  logic        a_st;
  logic [15:0] a_sc, a_fc;
  logic [31:0] b_s2, b_s3, b_s4, b_s5;
  logic        b_st;
  logic [3:0]  b_sc, b_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .inst_if(inst_if), .inst_if_vld(vld),
    .branch_taken(br), .dmem_ready(rdy),
    .inst_s2(a_s2), .inst_s3(a_s3), .inst_s4(a_s4), .inst_s5(a_s5),
    .stall_if(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  riscv_pipe_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .inst_if(inst_if), .inst_if_vld(vld),
    .branch_taken(br), .dmem_ready(rdy),
    .inst_s2(b_s2), .inst_s3(b_s3), .inst_s4(b_s4), .inst_s5(b_s5),
    .stall_if(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        vld;
    logic        br;
    logic        rdy;
    logic        st;
    logic [31:0] s2, s3, s4, s5;
    int          sc, fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] i, input logic v,
                     input logic b, input logic d, input logic st,
                     input logic [31:0] s2, input logic [31:0] s3,
                     input logic [31:0] s4, input logic [31:0] s5,
                     input int sc, input int fc);
    vec_t t;
    t.rst = r; t.inst = i; t.vld = v; t.br = b; t.rdy = d; t.st = st;
    t.s2 = s2; t.s3 = s3; t.s4 = s4; t.s5 = s5;
    t.sc = PERF ? sc : 0;
    t.fc = PERF ? fc : 0;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic v,
                       input logic b, input logic d);
    rst = r; inst_if = i; vld = v; br = b; rdy = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, N, 1'b0, 1'b0, 1'b1);

    // reset then a plain 4-instruction stream
    add(1, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    add(1, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    add(0, IA,  1, 0, 1, 0, IA,  N,   N,   N,   0, 0);
    add(0, IB,  1, 0, 1, 0, IB,  IA,  N,   N,   0, 0);
    add(0, IC,  1, 0, 1, 0, IC,  IB,  IA,  N,   0, 0);
    add(0, ID,  1, 0, 1, 0, ID,  IC,  IB,  IA,  0, 0);
    add(0, IA,  0, 0, 1, 0, N,   ID,  IC,  IB,  0, 0);
    add(0, N,   0, 0, 1, 0, N,   N,   ID,  IC,  0, 0);
    add(0, N,   0, 0, 1, 0, N,   N,   N,   ID,  0, 0);
    add(0, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    // load-use, one bubble
    add(1, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    add(0, LW,  1, 0, 1, 0, LW,  N,   N,   N,   0, 0);
    add(0, ADD, 1, 0, 1, 0, ADD, LW,  N,   N,   0, 0);
    add(0, IF7, 1, 0, 1, 1, ADD, N,   LW,  N,   1, 0);
    add(0, IF7, 1, 0, 1, 0, IF7, ADD, N,   LW,  1, 0);
    add(0, N,   0, 0, 1, 0, N,   IF7, ADD, N,   1, 0);
    // flush beats a pending load-use hazard
    add(1, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    add(0, LW,  1, 0, 1, 0, LW,  N,   N,   N,   0, 0);
    add(0, ADD, 1, 0, 1, 0, ADD, LW,  N,   N,   0, 0);
    add(0, IF7, 1, 1, 1, 0, N,   N,   LW,  N,   0, 1);
    add(0, N,   0, 0, 1, 0, N,   N,   N,   LW,  0, 1);
    // freeze beats flush; branch ignored while frozen
    add(1, N,   0, 0, 1, 0, N,   N,   N,   N,   0, 0);
    add(0, IA,  1, 0, 1, 0, IA,  N,   N,   N,   0, 0);
    add(0, IB,  1, 0, 1, 0, IB,  IA,  N,   N,   0, 0);
    add(0, IC,  1, 1, 0, 1, IB,  IA,  N,   N,   1, 0);
    add(0, IC,  1, 1, 0, 1, IB,  IA,  N,   N,   2, 0);
    add(0, IC,  1, 0, 1, 0, IC,  IB,  IA,  N,   2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].inst, tbl[i].vld, tbl[i].br, tbl[i].rdy);
      #1;
      if (!tbl[i].rst) chk($sformatf("v%0d.stall", i), 32'(a_st),
                           32'(tbl[i].st));
      step();
      chk($sformatf("v%0d.s2", i), a_s2, tbl[i].s2);
      chk($sformatf("v%0d.s3", i), a_s3, tbl[i].s3);
      chk($sformatf("v%0d.s4", i), a_s4, tbl[i].s4);
      chk($sformatf("v%0d.s5", i), a_s5, tbl[i].s5);
      chk($sformatf("v%0d.scnt", i), 32'(a_sc), tbl[i].sc);
      chk($sformatf("v%0d.fcnt", i), 32'(a_fc), tbl[i].fc);
    end

    // three bubbles with a 4-cycle freeze in the middle of HOLD
    drive(1, N, 0, 0, 1); step(); step();
    #1; chk("lu3.rst_stall", 32'(b_st), 0);
    drive(0, LW, 1, 0, 1);  step();
    drive(0, ADD, 1, 0, 1); step();
    drive(0, IF7, 1, 0, 1);
    #1; chk("lu3.b1_stall", 32'(b_st), 1);
    step();
    chk("lu3.b1_s3", b_s3, N);
    chk("lu3.b1_s2", b_s2, ADD);
    #1; chk("lu3.b2_stall", 32'(b_st), 1);
    step();
    chk("lu3.b2_s3", b_s3, N);
    chk("lu3.b2_s5", b_s5, LW);
    drive(0, IF7, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("frz%0d.stall", k), 32'(b_st), 1);
      step();
      chk($sformatf("frz%0d.s2", k), b_s2, ADD);
      chk($sformatf("frz%0d.s3", k), b_s3, N);
      chk($sformatf("frz%0d.s4", k), b_s4, N);
      chk($sformatf("frz%0d.s5", k), b_s5, LW);
    end
    drive(0, IF7, 1, 0, 1);
    #1; chk("lu3.b3_stall", 32'(b_st), 1);
    step();
    chk("lu3.b3_s3", b_s3, N);
    chk("lu3.b3_s2", b_s2, ADD);
    chk("lu3.b3_s5", b_s5, N);
    #1; chk("lu3.rel_stall", 32'(b_st), 0);
    step();
    chk("lu3.rel_s3", b_s3, ADD);
    chk("lu3.rel_s2", b_s2, IF7);
    chk("lu3.scnt", 32'(b_sc), PERF ? 7 : 0);

    // stall counter saturates at 4'hF
    drive(0, N, 0, 0, 0);
    repeat (20) step();
    chk("sat.scnt", 32'(b_sc), PERF ? 15 : 0);
    chk("sat.fcnt", 32'(b_fc), 0);

    // reset taken while frozen
    drive(0, IA, 1, 0, 1); step();
    drive(0, IB, 1, 0, 0); step();
    drive(1, IB, 1, 0, 0); step();
    chk("rstfrz.s2", b_s2, N);
    chk("rstfrz.s3", b_s3, N);
    chk("rstfrz.s4", b_s4, N);
    chk("rstfrz.s5", b_s5, N);
    chk("rstfrz.scnt", 32'(b_sc), 0);
    drive(0, N, 0, 0, 1);
    #1; chk("rstfrz.stall", 32'(b_st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
